eth_stream_wrr_arbiter: RTL and testbench
=========================================

ETH_STREAM_WRR_ARBITER -- requirements
Module: eth_stream_wrr_arbiter

Interface
REQ-001 Parameter NUM_REQS, default 4, number of requesters; SHALL be 2 to 32.
REQ-002 Parameter WEIGHT_W, default 4, width of each per-requester weight field.
REQ-003 Parameter REVERSE, default 0: 0 = lowest index first and rotation upward; 1 = highest index first and rotation downward.
REQ-004 Parameter INDEXW, default $clog2(NUM_REQS), width of grant_index.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid_req  input  NUM_REQS  per-requester request.
REQ-008 acknowledge  input  NUM_REQS  per-requester beat accepted downstream.
REQ-009 last  input  NUM_REQS  per-requester end-of-packet flag, qualified by acknowledge.
REQ-010 weights  input  NUM_REQS*WEIGHT_W  packets per turn; field i = bits [i*WEIGHT_W +: WEIGHT_W].
REQ-011 grant  output  NUM_REQS  registered one-hot grant.
REQ-012 valid  output  1  registered; high when a grant is held.
REQ-013 grant_index  output  INDEXW  registered binary index of grant.
REQ-014 credit_left  output  WEIGHT_W  registered packets remaining in current turn, including the one in flight.

Function
REQ-015 States: IDLE (valid=0) and GRANT (valid=1); grant, grant_index and credit_left SHALL all be registered, with no combinational path from inputs to outputs.
REQ-016 IDLE with any valid_req high -> GRANT on next edge; winner is first requester at or after the rotation pointer in REVERSE order, wrapping; if none is at or after the pointer, the first overall.
REQ-017 On every new winner i: credit_left loaded with weights[i]; weight 0 SHALL be treated as 1.
REQ-018 The grant SHALL be held, regardless of valid_req, until a release cycle in which acknowledge[g] and last[g] are both high for granted index g.
REQ-019 acknowledge without last, or acknowledge/last on non-granted indices, SHALL not change any state.
REQ-020 On release with credit_left > 1 and valid_req[g] high in that cycle: keep g, credit_left decrements by 1, pointer unchanged.
REQ-021 On release otherwise: pointer moves to one past g (one below if REVERSE), with wrap-around; re-arbitrate in the same cycle over that cycle's valid_req; if a winner exists, the new grant appears on the next edge with no idle cycle; if none, go to IDLE.
REQ-022 Wrap: pointer past NUM_REQS-1 (or below 0 if REVERSE) SHALL wrap to 0 (or NUM_REQS-1).
REQ-023 weights SHALL be sampled only at a winner load; changes mid-turn SHALL have no effect until the next load.
REQ-024 Only one requester SHALL ever be granted; grant SHALL equal 1 << grant_index whenever valid=1 and be zero when valid=0.
REQ-025 No starvation: a continuously requesting index SHALL be granted within sum over other indices of max(weight,1) packets.

Reset
REQ-026 reset high at any edge, including mid-packet: grant=0, valid=0, grant_index=0, credit_left=0, pointer=0, state IDLE; reset overrides any release in the same cycle.
REQ-027 The first arbitration after reset SHALL start from index 0 (NUM_REQS-1 if REVERSE).

Configuration
REQ-028 Macro ETH_ARB_WEIGHTS_EN defined: weighted behaviour as REQ-017/REQ-020.
REQ-029 ETH_ARB_WEIGHTS_EN undefined: weights port present but ignored; every turn is one packet; credit_left held at 1 in GRANT and 0 in IDLE; plain packet-level round-robin.

Verification
REQ-030 Reset, then valid_req=4'b0110 -> next edge grant=4'b0010, grant_index=1, valid=1, credit_left=weights[1].
REQ-031 Weights {1,1,3,1} (index 3..0), all requesting, ack+last each cycle -> grant sequence 0,1,1,1,2,3,0,... with credit_left on index 1 going 3,2,1; no idle cycle between grants.
REQ-032 Granted index 2 drops valid_req mid-packet with credit 3 -> grant held until ack+last, then moves to next requester, not back to 2.
REQ-033 Weight field = 0 for index 0, only index 0 requesting -> one packet per turn, re-granted after each release via wrap, credit_left=1.
REQ-034 REVERSE=1, all requesting, weights all 1 -> order 3,2,1,0,3.
REQ-035 reset asserted mid-packet with grant=4'b1000 -> next edge all outputs 0; after release of reset, valid_req=4'b1001 -> grant=4'b0001.

Source files
------------

// File: rtl/eth_stream_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter for streaming requesters.
// Define ETH_ARB_WEIGHTS_EN to enable per-requester packet weights; otherwise each turn is one packet.
module eth_stream_wrr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int WEIGHT_W = 4,
  parameter int REVERSE  = 0,
  parameter int INDEXW   = $clog2(NUM_REQS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          valid_req,
  input  logic [NUM_REQS-1:0]          acknowledge,
  input  logic [NUM_REQS-1:0]          last,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  output logic [NUM_REQS-1:0]          grant,
  output logic                         valid,
  output logic [INDEXW-1:0]            grant_index,
  output logic [WEIGHT_W-1:0]          credit_left
);

  localparam int unsigned N = NUM_REQS;
  localparam logic [INDEXW-1:0] LAST_IDX = INDEXW'(NUM_REQS - 1);
  // Reverse mode keeps its pointer at the top index so the first search begins there.
  localparam logic [INDEXW-1:0] PTR_RST = (REVERSE != 0) ? LAST_IDX : '0;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e                state_q, state_d;
  logic [INDEXW-1:0]     ptr_q, ptr_d;
  logic [INDEXW-1:0]     idx_q, idx_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [NUM_REQS-1:0]   grant_q, grant_d;

  logic [INDEXW-1:0]     ptr_step;
  logic [INDEXW:0]       pick_idle, pick_rel;
  logic [WEIGHT_W-1:0]   credit_idle, credit_rel;
  logic                  release_beat;
  logic                  keep_turn;

  // Returns {found, index}: first requester at or after start in search direction, wrapping.
  function automatic logic [INDEXW:0] pick(input logic [NUM_REQS-1:0] req,
                                            input logic [INDEXW-1:0]   start);
    logic              found;
    logic [INDEXW-1:0] sel;
    int unsigned       pos;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (REVERSE != 0) pos = (32'(start) + N - k) % N;
      else              pos = (32'(start) + k) % N;
      if (!found && req[INDEXW'(pos)]) begin
        found = 1'b1;
        sel   = INDEXW'(pos);
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    ptr_step = '0;
    if (REVERSE != 0) ptr_step = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    else              ptr_step = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  end

  assign pick_idle    = pick(valid_req, ptr_q);
  assign pick_rel     = pick(valid_req, ptr_step);
  assign release_beat = (state_q == GRANT) && acknowledge[idx_q] && last[idx_q];

`ifdef ETH_ARB_WEIGHTS_EN
  logic [WEIGHT_W-1:0] w_arr [NUM_REQS];
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_weight
    assign w_arr[gi] = weights[gi*WEIGHT_W +: WEIGHT_W];
  end

  function automatic logic [WEIGHT_W-1:0] nonzero(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign credit_idle = nonzero(w_arr[pick_idle[INDEXW-1:0]]);
  assign credit_rel  = nonzero(w_arr[pick_rel[INDEXW-1:0]]);
  assign keep_turn   = (credit_q > WEIGHT_W'(1)) && valid_req[idx_q];
`else
  logic unused_weights;
  assign unused_weights = ^weights;
  assign credit_idle    = WEIGHT_W'(1);
  assign credit_rel     = WEIGHT_W'(1);
  assign keep_turn      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[INDEXW]) begin
          state_d  = GRANT;
          idx_d    = pick_idle[INDEXW-1:0];
          credit_d = credit_idle;
        end
      end
      GRANT: begin
        if (release_beat) begin
          if (keep_turn) begin
            credit_d = credit_q - 1'b1;
          end else begin
            // Rotate past the finished requester and re-arbitrate in the same cycle.
            ptr_d = ptr_step;
            if (pick_rel[INDEXW]) begin
              idx_d    = pick_rel[INDEXW-1:0];
              credit_d = credit_rel;
            end else begin
              state_d  = IDLE;
              idx_d    = '0;
              credit_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == GRANT) ? (NUM_REQS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_RST;
      idx_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign valid       = (state_q == GRANT);
  assign grant_index = idx_q;
  assign credit_left = credit_q;

endmodule

// File: tb/tb_eth_stream_wrr_arbiter.sv
// Self-checking bench: forward and reverse arbiters driven in parallel against a packet-level model.
module tb_eth_stream_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
`ifdef ETH_ARB_WEIGHTS_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  vreq, ack, lst;
  logic [15:0] wts;
  logic [3:0]  gnt0, gnt1, cr0, cr1;
  logic        vld0, vld1;
  logic [1:0]  idx0, idx1;
  logic [10:0] obs [2];

  eth_stream_wrr_arbiter #(.NUM_REQS(N), .WEIGHT_W(WW), .REVERSE(0)) u_fwd (
    .clk(clk), .reset(rst), .valid_req(vreq), .acknowledge(ack), .last(lst),
    .weights(wts), .grant(gnt0), .valid(vld0), .grant_index(idx0), .credit_left(cr0)
  );

  eth_stream_wrr_arbiter #(.NUM_REQS(N), .WEIGHT_W(WW), .REVERSE(1)) u_rev (
    .clk(clk), .reset(rst), .valid_req(vreq), .acknowledge(ack), .last(lst),
    .weights(wts), .grant(gnt1), .valid(vld1), .grant_index(idx1), .credit_left(cr1)
  );

  assign obs[0] = {gnt0, vld0, idx0, cr0};
  assign obs[1] = {gnt1, vld1, idx1, cr1};

  int checks = 0;
  int passes = 0;

  // Model state per instance: 0 = forward, 1 = reverse.
  int m_valid [2];
  int m_g     [2];
  int m_cred  [2];
  int m_ptr   [2];

  function automatic bit bit_of(logic [3:0] v, int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // First requester at or after p in the search order; otherwise the first overall.
  function automatic int arb(int m, int p, logic [3:0] req);
    if (m == 0) begin
      for (int i = p; i < N; i++) if (bit_of(req, i)) return i;
      for (int i = 0; i < N; i++) if (bit_of(req, i)) return i;
    end else begin
      for (int i = p; i >= 0; i--) if (bit_of(req, i)) return i;
      for (int i = N - 1; i >= 0; i--) if (bit_of(req, i)) return i;
    end
    return -1;
  endfunction

  function automatic void load(int m, int i);
    int w;
    w = int'((wts >> (4 * i)) & 16'hF);
    m_valid[m] = 1;
    m_g[m]     = i;
    m_cred[m]  = WEN ? ((w == 0) ? 1 : w) : 1;
  endfunction

  function automatic void model_step(int m);
    int w;
    if (rst) begin
      m_valid[m] = 0; m_g[m] = 0; m_cred[m] = 0;
      m_ptr[m]   = (m == 0) ? 0 : N - 1;
    end else if (m_valid[m] == 0) begin
      w = arb(m, m_ptr[m], vreq);
      if (w >= 0) load(m, w);
    end else if (bit_of(ack, m_g[m]) && bit_of(lst, m_g[m])) begin
      if (WEN && m_cred[m] > 1 && bit_of(vreq, m_g[m])) begin
        m_cred[m] = m_cred[m] - 1;
      end else begin
        if (m == 0) m_ptr[m] = (m_g[m] + 1) % N;
        else        m_ptr[m] = (m_g[m] + N - 1) % N;
        w = arb(m, m_ptr[m], vreq);
        if (w >= 0) load(m, w);
        else begin m_valid[m] = 0; m_g[m] = 0; m_cred[m] = 0; end
      end
    end
  endfunction

  function automatic logic [10:0] exp_out(int m);
    logic [3:0] g;
    g = (m_valid[m] != 0) ? (4'b0001 << m_g[m]) : 4'b0000;
    return {g, m_valid[m] != 0, 2'(m_g[m]), 4'(m_cred[m])};
  endfunction

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vreq = '1; ack = '1; lst = '1; wts = 16'($urandom);
    cyc(); cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== 11'b0) $display("FAIL reset dut%0d got %h expected %h", m, obs[m], 11'b0);
      else passes++;
    end
  endtask

  task automatic test_first_grant();
    rst = 1'b1; cyc();
    rst = 1'b0; wts = 16'h1131; vreq = 4'b0110; ack = '0; lst = '0;
    cyc();
    checks++;
    if ({gnt0, vld0, idx0, cr0} !== {4'b0010, 1'b1, 2'd1, WEN ? 4'd3 : 4'd1})
      $display("FAIL first_grant got g=%b v=%b i=%0d c=%0d", gnt0, vld0, idx0, cr0);
    else passes++;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== exp_out(m)) $display("FAIL first_grant_model dut%0d got %h expected %h", m, obs[m], exp_out(m));
      else passes++;
    end
  endtask

  task automatic test_weighted_sequence();
    int ei [7];
    int ec [7];
    if (WEN) begin ei = '{0, 1, 1, 1, 2, 3, 0}; ec = '{1, 3, 2, 1, 1, 1, 1}; end
    else     begin ei = '{0, 1, 2, 3, 0, 1, 2}; ec = '{1, 1, 1, 1, 1, 1, 1}; end
    rst = 1'b1; wts = 16'h1131; vreq = '1; ack = '1; lst = '1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      checks++;
      if ({vld0, idx0, cr0} !== {1'b1, 2'(ei[k]), 4'(ec[k])})
        $display("FAIL wrr_seq step%0d got v=%b i=%0d c=%0d expected i=%0d c=%0d", k, vld0, idx0, cr0, ei[k], ec[k]);
      else passes++;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_out(m)) $display("FAIL wrr_seq_model dut%0d got %h expected %h", m, obs[m], exp_out(m));
        else passes++;
      end
    end
  endtask

  task automatic test_reverse();
    int ei [5];
    ei = '{3, 2, 1, 0, 3};
    rst = 1'b1; wts = 16'h1111; vreq = '1; ack = '1; lst = '1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if ({vld1, gnt1, idx1} !== {1'b1, 4'b0001 << ei[k], 2'(ei[k])})
        $display("FAIL reverse step%0d got g=%b i=%0d expected i=%0d", k, gnt1, idx1, ei[k]);
      else passes++;
    end
  endtask

  task automatic test_drop_mid_packet();
    logic [3:0] acks [3];
    logic [3:0] lsts [3];
    acks = '{4'b1111, 4'b1011, 4'b0000};
    lsts = '{4'b1011, 4'b1111, 4'b0000};
    rst = 1'b1; cyc();
    rst = 1'b0; wts = 16'h0300; vreq = 4'b0100; ack = '0; lst = '0;
    cyc();
    vreq = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      ack = acks[k]; lst = lsts[k];
      cyc();
      checks++;
      if ({vld0, idx0, cr0} !== {1'b1, 2'd2, WEN ? 4'd3 : 4'd1})
        $display("FAIL drop_hold step%0d got v=%b i=%0d c=%0d expected i=2", k, vld0, idx0, cr0);
      else passes++;
    end
    ack = 4'b0100; lst = 4'b0100;
    cyc();
    checks++;
    if ({vld0, gnt0, idx0} !== {1'b1, 4'b1000, 2'd3})
      $display("FAIL drop_move got g=%b i=%0d expected g=1000 i=3", gnt0, idx0);
    else passes++;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== exp_out(m)) $display("FAIL drop_model dut%0d got %h expected %h", m, obs[m], exp_out(m));
      else passes++;
    end
  endtask

  task automatic test_zero_weight();
    rst = 1'b1; cyc();
    rst = 1'b0; wts = 16'h1110; vreq = 4'b0001; ack = '1; lst = '1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {4'b0001, 1'b1, 2'd0, 4'd1})
          $display("FAIL zero_weight step%0d dut%0d got %h expected %h", k, m, obs[m], {4'b0001, 1'b1, 2'd0, 4'd1});
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    rst = 1'b1; cyc();
    rst = 1'b0; wts = 16'h2222; vreq = 4'b1000; ack = '0; lst = '0;
    cyc();
    checks++;
    if (gnt0 !== 4'b1000) $display("FAIL rst_mid_pre got %b expected 1000", gnt0);
    else passes++;
    rst = 1'b1; ack = 4'b1000; lst = 4'b1000;
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== 11'b0) $display("FAIL rst_mid_clear dut%0d got %h expected %h", m, obs[m], 11'b0);
      else passes++;
    end
    rst = 1'b0; vreq = 4'b1001; ack = '0; lst = '0;
    cyc();
    checks++;
    if ({gnt0, gnt1} !== {4'b0001, 4'b1000})
      $display("FAIL rst_mid_after got fwd=%b rev=%b expected fwd=0001 rev=1000", gnt0, gnt1);
    else passes++;
  endtask

  task automatic test_random();
    rst = 1'b1; cyc();
    for (int k = 0; k < 1500; k++) begin
      rst  = ($urandom_range(0, 63) == 0);
      vreq = 4'($urandom);
      ack  = 4'($urandom);
      lst  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) wts = 16'($urandom);
      cyc();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_out(m))
          $display("FAIL random cycle%0d dut%0d got %h expected %h", k, m, obs[m], exp_out(m));
        else passes++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; vreq = '0; ack = '0; lst = '0; wts = '0;
    test_reset();
    test_first_grant();
    test_weighted_sequence();
    test_reverse();
    test_drop_mid_packet();
    test_zero_weight();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
